imem_responder: RTL and testbench

//  Instruction-memory responder: the memory side of the fetch-address interface driven by the PC.

---
 rtl/imem_responder_pkg.sv | 17 +
 rtl/imem_sram.sv | 34 +++
 rtl/imem_responder.sv | 123 ++++++++++++
 tb/tb_imem_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encoding,
// default memory base address and error classification codes.
package imem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] IMEM_BASE = 32'h8000_0000;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;

endpackage

// File: rtl/imem_sram.sv
// Single-port-write / single-read word array. The read is sampled into a
// register on the read strobe and holds until the next strobe.
module imem_sram #(
  parameter int DEPTH  = 4096,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array has no reset so that loaded contents survive a responder reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Non-blocking read returns the pre-write value on a same-edge collision.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Memory side of the fetch-address interface: one outstanding request,
// fixed-latency response, error flag for misaligned or out-of-range fetches.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int              ADDR_W  = 32,
  parameter int              DATA_W  = 32,
  parameter logic [ADDR_W-1:0] BASE  = IMEM_BASE,
  parameter int              DEPTH   = 4096,
  parameter int              LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [1:0]        dbg_state_o
);

  // Handshakes: a transfer happens on a posedge where valid && ready are both
  // high; requesters hold valid (and payload) until ready, the responder holds
  // resp_valid/resp_data/resp_err stable until resp_ready.

  localparam int              IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN   = ADDR_W'(DEPTH * 4);
  localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              err_q;

  logic [ADDR_W-1:0] req_off;
  logic [ADDR_W-1:0] wr_off;
  logic [1:0]        req_err_code;
  logic              accept;
  logic              rd_en;
  logic              wr_ok;
  logic [DATA_W-1:0] sram_rdata;

  // Offset subtraction wraps, so addresses below BASE land far above SPAN.
  assign req_off = req_addr - BASE;
  assign wr_off  = wr_addr - BASE;

  always_comb begin
    req_err_code = ERR_NONE;
    if (req_addr[1:0] != 2'b00) req_err_code = ERR_MISALIGN;
    else if (req_off >= SPAN)   req_err_code = ERR_RANGE;
  end

  assign accept = rst && req_valid && req_ready_q;
  assign rd_en  = accept && (req_err_code == ERR_NONE);
  assign wr_ok  = rst && wr_en && (wr_off < SPAN);

  imem_sram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_sram (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (wr_ok),
    .waddr_i (wr_off[IDX_W+1:2]),
    .wdata_i (wr_data),
    .re_i    (rd_en),
    .raddr_i (req_off[IDX_W+1:2]),
    .rdata_o (sram_rdata)
  );

  // WAIT is always visited once; cnt counts the remaining WAIT cycles so that
  // resp_valid rises LATENCY edges after acceptance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q     <= ST_WAIT;
            cnt_q       <= CNT_INIT;
            req_ready_q <= 1'b0;
            err_q       <= (req_err_code != ERR_NONE);
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = err_q;
  assign resp_data   = err_q ? '0 : sram_rdata;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_responder.sv
// Scenario bench for imem_responder: reset, good fetches, backpressure,
// error classes, loader hazards and reset during an outstanding fetch.
module tb_imem_responder;
  import imem_responder_pkg::*;

  localparam int          LAT  = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [1:0]  dbg_state;

  logic [32:0] exp_q[$];
  logic [31:0] mdl [0:4095];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  imem_responder #(
    .ADDR_W (32), .DATA_W (32), .BASE (BASE), .DEPTH (4096), .LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .dbg_state_o(dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference behaviour: {err, data} for a fetch of byte address a.
  function automatic logic [32:0] model_exp(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (a[1:0] != 2'b00 || off >= 32'd16384) return {1'b1, 32'h0};
    return {1'b0, mdl[off[13:2]]};
  endfunction

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    off = a - BASE;
    if (off < 32'd16384) mdl[off[13:2]] = d;
  endtask

  // hz: 0 none, 1 loader write to same word at acceptance edge, 2 during WAIT
  task automatic run_txn(input logic [31:0] a, input int hold, input int hz, input string nm);
    logic [32:0] exp;
    logic [31:0] off;
    int guard;
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; resp_ready = 1'b0;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s req_ready_timeout: got %b want 1", nm, req_ready);
      req_valid = 1'b0;
      return;
    end
    if (hz == 1) begin wr_en = 1'b1; wr_addr = a; wr_data = 32'hDEAD_BEEF; end
    exp_q.push_back(model_exp(a));
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (hz == 2) begin wr_en = 1'b1; wr_addr = a; wr_data = 32'hDEAD_BEEF; end
    else wr_en = 1'b0;
    off = a - BASE;
    if (hz != 0 && a[1:0] == 2'b00 && off < 32'd16384) mdl[off[13:2]] = 32'hDEAD_BEEF;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; wr_en = 1'b0; lat++; end
    wr_en = 1'b0;
    n_cmp++;
    if (lat != LAT) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", nm, lat, LAT);
    end
    exp = exp_q[0];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || {resp_err, resp_data} !== exp) begin
        n_err++;
        $display("FAIL %s hold[%0d]: got v=%b rdy=%b err/data=%h want v=1 rdy=0 err/data=%h",
                 nm, i, resp_valid, req_ready, {resp_err, resp_data}, exp);
      end
    end
    @(negedge clk);
    resp_ready = 1'b1;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s scoreboard_empty: got 0 entries want 1", nm);
    end else begin
      exp = exp_q.pop_front();
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || {resp_err, resp_data} !== exp) begin
        n_err++;
        $display("FAIL %s resp: got v=%b rdy=%b err/data=%h want v=1 rdy=0 err/data=%h",
                 nm, resp_valid, req_ready, {resp_err, resp_data}, exp);
      end
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL %s complete: got v=%b rdy=%b st=%0d want v=0 rdy=1 st=%0d",
               nm, resp_valid, req_ready, dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b1; req_addr = BASE;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'h0 ||
          resp_err !== 1'b0 || dbg_state !== ST_IDLE) begin
        n_err++;
        $display("FAIL reset[%0d]: got rdy=%b v=%b d=%h e=%b st=%0d want 1 0 0 0 %0d",
                 i, req_ready, resp_valid, resp_data, resp_err, dbg_state, ST_IDLE);
      end
    end
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
  endtask

  task automatic test_basic();
    load_word(BASE, 32'h0000_0413);
    for (int i = 1; i < 8; i++) load_word(BASE + 32'(4 * i), $urandom);
    load_word(BASE + 32'h3FFC, 32'h0BAD_F00D);
    load_word(BASE + 32'h4000, 32'h1234_5678);
    run_txn(BASE, 0, 0, "basic_word0");
    run_txn(BASE + 32'h3FFC, 0, 0, "basic_last_word");
  endtask

  task automatic test_backpressure();
    run_txn(BASE + 32'h4, 5, 0, "backpressure");
  endtask

  task automatic test_errors();
    run_txn(32'h8000_0002, 0, 0, "err_misaligned");
    run_txn(32'h7FFF_FFFC, 1, 0, "err_below_base");
    run_txn(32'h8000_4000, 0, 0, "err_past_end");
    run_txn(32'hFFFF_FFFC, 0, 0, "err_top_of_space");
    run_txn(32'h0000_0000, 0, 0, "err_zero");
  endtask

  task automatic test_hazard();
    run_txn(BASE + 32'h8, 0, 2, "hazard_wait_old");
    run_txn(BASE + 32'h8, 0, 0, "hazard_wait_new");
    run_txn(BASE + 32'hC, 1, 1, "hazard_accept_old");
    run_txn(BASE + 32'hC, 0, 0, "hazard_accept_new");
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    req_valid = 1'b1; req_addr = BASE + 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      n_cmp++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
        n_err++;
        $display("FAIL rst_in_wait[%0d]: got v=%b rdy=%b st=%0d want v=0 rdy=1 st=%0d",
                 i, resp_valid, req_ready, dbg_state, ST_IDLE);
      end
      @(posedge clk); #1;
    end
    run_txn(BASE + 32'h10, 0, 0, "rst_retained");
    run_txn(BASE, 0, 0, "no_alias_word0");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    int r;
    for (int n = 0; n < 10; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8) a = BASE + 32'(4 * r);
      else if (r == 8) a = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
      else a = 32'($urandom_range(0, 32'h7FFF_FFFF));
      run_txn(a, $urandom_range(0, 2), 0, "back_to_back");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_errors();
    test_hazard();
    test_reset_in_wait();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expected: got %0d entries want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
